// File: rtl/regfile_pkg.sv
// Shared widths, register-file constants and the write-request record used by
// the register-file write arbiter and its scoreboard.
package regfile_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Tracks destination registers that still owe a port-B writeback and reports
// RAW hazards for the two decode-stage source operands.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic              o_rs_busy,
  output logic              o_rt_busy,
  output logic              o_sb_conflict
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_next;
  logic                r_conflict;
  logic                w_set_ok;

  assign w_set_ok = i_set && (i_set_addr != REG_ZERO);

  // Next pending vector: clear on port-B fire, then set so a same-cycle issue wins.
  always_comb begin
    w_pending_next = r_pending;
    if (i_clr) begin
      w_pending_next[i_clr_addr] = 1'b0;
    end else begin
      w_pending_next = r_pending;
    end
    if (w_set_ok) begin
      w_pending_next[i_set_addr] = 1'b1;
    end else begin
      w_pending_next[i_set_addr] = w_pending_next[i_set_addr];
    end
  end

  // Pending vector and conflict pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= {NUM_REGS{1'b0}};
      r_conflict <= 1'b0;
    end else begin
      r_pending  <= w_pending_next;
      r_conflict <= w_set_ok && r_pending[i_set_addr];
    end
  end

  assign o_rs_busy     = (i_rs_addr != REG_ZERO) && r_pending[i_rs_addr];
  assign o_rt_busy     = (i_rt_addr != REG_ZERO) && r_pending[i_rt_addr];
  assign o_sb_conflict = r_conflict;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the main writeback
// (A) and a multi-cycle unit (B), with anti-starvation forcing for B.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_issue,
  input  logic [ADDR_W-1:0] b_issue_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              sb_conflict,
  output logic              write,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_Data
);
  import regfile_pkg::wr_req_t;
  import regfile_pkg::REG_ZERO;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        r_starve;
  logic              w_force_b;
  logic              w_a_fire;
  logic              w_b_fire;
  wr_req_t           w_sel;
  logic              r_write;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  assign w_force_b = b_valid && (r_starve == LP_LIMIT);
  assign a_ready   = !reset && !w_force_b;
  assign b_ready   = !reset && (!a_valid || w_force_b);
  assign w_a_fire  = a_valid && a_ready;
  assign w_b_fire  = b_valid && b_ready;

  // Select the winning request; A and B never fire together.
  always_comb begin
    w_sel = '{addr: b_addr, data: b_data};
    if (w_a_fire) begin
      w_sel = '{addr: a_addr, data: a_data};
    end else begin
      w_sel = '{addr: b_addr, data: b_data};
    end
  end

  // Starvation counter: counts refused B cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (w_b_fire || !b_valid) begin
      r_starve <= 4'd0;
    end else if (r_starve != LP_LIMIT) begin
      r_starve <= r_starve + 4'd1;
    end else begin
      r_starve <= r_starve;
    end
  end

  // Register-file outputs; address/data only move on a real (nonzero) write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write   <= 1'b0;
      r_wr_addr <= {ADDR_W{1'b0}};
      r_wr_data <= {DATA_W{1'b0}};
    end else if ((w_a_fire || w_b_fire) && (w_sel.addr != REG_ZERO)) begin
      r_write   <= 1'b1;
      r_wr_addr <= w_sel.addr;
      r_wr_data <= w_sel.data;
    end else begin
      r_write   <= 1'b0;
      r_wr_addr <= r_wr_addr;
      r_wr_data <= r_wr_data;
    end
  end

  assign write         = r_write;
  assign write_address = r_wr_addr;
  assign write_Data    = r_wr_data;

  regfile_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .i_set         (b_issue),
    .i_set_addr    (b_issue_addr),
    .i_clr         (w_b_fire),
    .i_clr_addr    (b_addr),
    .i_rs_addr     (rs_addr),
    .i_rt_addr     (rt_addr),
    .o_rs_busy     (rs_busy),
    .o_rt_busy     (rt_busy),
    .o_sb_conflict (sb_conflict)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (STARVE_LIMIT = 4).
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, b_issue_addr, rs_addr, rt_addr;
  logic [31:0] a_data, b_data;
  logic        b_issue, rs_busy, rt_busy, sb_conflict;
  logic        write;
  logic [4:0]  write_address;
  logic [31:0] write_Data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .b_issue(b_issue), .b_issue_addr(b_issue_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .sb_conflict(sb_conflict),
    .write(write), .write_address(write_address), .write_Data(write_Data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'd0;
    b_issue = 1'b0; b_issue_addr = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
    tick();
    tick();
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_waddr", 32'(write_address), 32'd0);
    chk("rst_wdata", write_Data, 32'd0);
    chk("rst_conflict", 32'(sb_conflict), 32'd0);
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();

    // A only
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF;
    #1 chk("a_only_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("a_only_write", 32'(write), 32'd1);
    chk("a_only_addr", 32'(write_address), 32'd3);
    chk("a_only_data", write_Data, 32'hDEADBEEF);
    tick();
    chk("a_only_write_low", 32'(write), 32'd0);
    chk("a_only_addr_hold", 32'(write_address), 32'd3);

    // Starvation: A held continuously, B forced on the 5th cycle
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11111111;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      #1 chk("starve_a_ready", 32'(a_ready), 32'd1);
      chk("starve_b_ready", 32'(b_ready), 32'd0);
      tick();
      chk("starve_a_waddr", 32'(write_address), 32'd1);
    end
    #1 chk("force_a_ready", 32'(a_ready), 32'd0);
    chk("force_b_ready", 32'(b_ready), 32'd1);
    tick();
    chk("force_write", 32'(write), 32'd1);
    chk("force_waddr", 32'(write_address), 32'd2);
    chk("force_wdata", write_Data, 32'h22222222);
    b_addr = 5'd4; b_data = 32'h44444444;
    #1 chk("cnt_clear_a_ready", 32'(a_ready), 32'd1);
    chk("cnt_clear_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("resume_waddr", 32'(write_address), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("idle_write", 32'(write), 32'd0);

    // Scoreboard busy on addr 7
    b_issue = 1'b1; b_issue_addr = 5'd7; rs_addr = 5'd7; rt_addr = 5'd8;
    #1 chk("rs_busy_pre", 32'(rs_busy), 32'd0);
    tick();
    b_issue = 1'b0;
    chk("rs_busy_set", 32'(rs_busy), 32'd1);
    chk("rt_busy_other", 32'(rt_busy), 32'd0);
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h00000077;
    #1 chk("b7_ready", 32'(b_ready), 32'd1);
    chk("rs_busy_fire_cycle", 32'(rs_busy), 32'd1);
    tick();
    b_valid = 1'b0;
    chk("b7_write", 32'(write), 32'd1);
    chk("b7_waddr", 32'(write_address), 32'd7);
    chk("b7_wdata", write_Data, 32'h00000077);
    chk("rs_busy_drop", 32'(rs_busy), 32'd0);

    // Zero register writes and issue
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0000AAAA;
    #1 chk("z_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("z_a_write", 32'(write), 32'd0);
    chk("z_a_addr_hold", 32'(write_address), 32'd7);
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000BBBB;
    #1 chk("z_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    chk("z_b_write", 32'(write), 32'd0);
    chk("z_b_data_hold", write_Data, 32'h00000077);
    b_issue = 1'b1; b_issue_addr = 5'd0; rs_addr = 5'd0;
    tick();
    chk("z_issue_busy", 32'(rs_busy), 32'd0);
    tick();
    b_issue = 1'b0;
    chk("z_issue_conflict", 32'(sb_conflict), 32'd0);

    // Same-cycle issue and fire on addr 9, then a conflicting reissue
    rt_addr = 5'd9;
    b_issue = 1'b1; b_issue_addr = 5'd9;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h00000099;
    #1 chk("b9_ready", 32'(b_ready), 32'd1);
    tick();
    b_issue = 1'b0; b_valid = 1'b0;
    chk("set_wins_busy", 32'(rt_busy), 32'd1);
    chk("set_wins_conflict", 32'(sb_conflict), 32'd0);
    chk("b9_waddr", 32'(write_address), 32'd9);
    b_issue = 1'b1; b_issue_addr = 5'd9;
    tick();
    b_issue = 1'b0;
    chk("conflict_pulse", 32'(sb_conflict), 32'd1);
    tick();
    chk("conflict_one_cycle", 32'(sb_conflict), 32'd0);
    chk("b9_still_busy", 32'(rt_busy), 32'd1);

    // Reset the cycle after a fire
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h00000055;
    tick();
    reset = 1'b1; b_valid = 1'b1; b_addr = 5'd6;
    #1 chk("rst_mid_a_ready", 32'(a_ready), 32'd0);
    chk("rst_mid_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("rst_mid_write", 32'(write), 32'd0);
    chk("rst_mid_waddr", 32'(write_address), 32'd0);
    chk("rst_mid_rt_busy", 32'(rt_busy), 32'd0);
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("post_rst_write", 32'(write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
